// File: rtl/lcd_spi_streamer.sv
// lcd_spi_streamer
//   Takes the PPU pixel stream, buffers it in a small FIFO, maps each 2-bit
//   shade to RGB565 and serialises it MSB-first over SPI mode 0 to an
//   ST7789-class panel. A RAMWR (0x2C) command byte precedes the first pixel
//   of every frame.
//
// Ports
//   clk, rst_n             clock (clk_4mhz domain), async active-low reset
//   lcd_write              pixel strobe, one pixel per cycle
//   lcd_col[1:0]           pixel shade
//   lcd_x[7:0], lcd_y[7:0] pixel coordinate (valid: x<160, y<144)
//   spi_sck, spi_mosi      SPI clock (idle low) and data
//   spi_cs_n, spi_dc       chip select (active low), 0=command / 1=data
//   busy                   FIFO non-empty, byte in flight or cs_n asserted
//   overflow               sticky: a valid pixel was dropped on a full FIFO
//   state                  FSM state (debug)
//
// Handshake: the pixel input has no back-pressure. A valid pixel is accepted
// when the FIFO is not full, or when it is full and the FSM pops in the same
// cycle; otherwise it is dropped and overflow latches.
module lcd_spi_streamer #(
  parameter int          DEPTH   = 16,
  parameter int          CLK_DIV = 1,
  parameter logic [15:0] PAL0    = 16'hFFFF,
  parameter logic [15:0] PAL1    = 16'hAD55,
  parameter logic [15:0] PAL2    = 16'h52AA,
  parameter logic [15:0] PAL3    = 16'h0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_write,
  input  logic [1:0] lcd_col,
  input  logic [7:0] lcd_x,
  input  logic [7:0] lcd_y,
  output logic       spi_sck,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       spi_dc,
  output logic       busy,
  output logic       overflow,
  output logic [1:0] state
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CMD    = 2'd1;
  localparam logic [1:0] PIX_HI = 2'd2;
  localparam logic [1:0] PIX_LO = 2'd3;

  // ---------------- FIFO ----------------
  logic [2:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pix_valid, push, pop;
  logic [2:0]    head;
  logic [15:0]   head_pal;

  assign pix_valid = lcd_write && (lcd_x < 8'd160) && (lcd_y < 8'd144);
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push      = pix_valid && (!full || pop);
  assign head      = mem[rd_ptr[AW-1:0]];

  always_comb begin
    head_pal = PAL0;
    case (head[1:0])
      2'd0: head_pal = PAL0;
      2'd1: head_pal = PAL1;
      2'd2: head_pal = PAL2;
      2'd3: head_pal = PAL3;
      default: head_pal = PAL0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {(lcd_x == 8'd0) && (lcd_y == 8'd0), lcd_col};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pix_valid && full && !pop) overflow <= 1'b1;
    end
  end

  // ---------------- Shifter datapath ----------------
  logic [1:0]    state_next;
  logic [DW-1:0] div_cnt;
  logic          phase;      // current SCK level while a byte is in flight
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [15:0]   pal;
  logic          div_last, byte_done;

  assign div_last  = (div_cnt == DW'(CLK_DIV - 1));
  assign byte_done = (state != IDLE) && phase && div_last && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
      pal     <= '0;
    end else if (pop) begin
      pal     <= head_pal;
      shreg   <= head[2] ? 8'h2C : head_pal[15:8];
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
    end else if (state != IDLE) begin
      if (div_last) begin
        div_cnt <= '0;
        phase   <= ~phase;
        // Falling edge: advance to the next bit, or load the next byte of
        // the pixel. After PIX_LO the load is harmless; mosi is gated in IDLE.
        if (phase) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) shreg <= (state == CMD) ? pal[15:8] : pal[7:0];
          else                 shreg <= {shreg[6:0], 1'b0};
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop        = 1'b1;
        state_next = head[2] ? CMD : PIX_HI;
      end
      CMD:    if (byte_done) state_next = PIX_HI;
      PIX_HI: if (byte_done) state_next = PIX_LO;
      PIX_LO: if (byte_done) begin
        // Chain straight into the next pixel so cs_n and sck run gap-free.
        if (!empty) begin
          pop        = 1'b1;
          state_next = head[2] ? CMD : PIX_HI;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    spi_cs_n = (state == IDLE);
    spi_sck  = (state != IDLE) && phase;
    spi_mosi = (state != IDLE) && shreg[7];
    spi_dc   = (state != CMD);
    busy     = !empty || (state != IDLE) || !spi_cs_n;
  end

endmodule
